ptmch_evlog: RTL and testbench

- Trigger event logger directly downstream of the SPI pattern-trigger stage; consumes the 5-bit TRG_PLS vector in the CLK160M domain.
- Detects the rising edge of each trigger bit and stamps it with a free-running 27-bit cycle counter.
- Stores each stamped event as a 32-bit entry in a FIFO, together with an overflow count.
- A downstream register/CDC stage drains the FIFO through a request/valid read port, so firmware can reconstruct the command sequence and its timing.

---
 rtl/ptmch_evlog.sv | 124 ++++++++++++
 tb/tb_ptmch_evlog.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ptmch_evlog.sv
// Trigger event logger: rising edges of TRG_PLS are stamped with a free-running
// cycle counter and queued in a FIFO that is drained through a request/valid port.
module ptmch_evlog #(
  parameter int DEPTH = 64,
  parameter int TS_W  = 27
) (
  input  logic                     CLK160M,
  input  logic                     RESET_N,
  input  logic [4:0]               TRG_PLS,
  input  logic                     LOG_EN,
  input  logic                     LOG_CLR,
  input  logic                     RD_REQ,
  output logic [31:0]              RD_DATA,
  output logic                     RD_VALID,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [15:0]              OVF_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0] ts_reg;
  logic [4:0]      trg_d_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic [LW-1:0]   level_next;
  logic            empty_reg;
  logic            full_reg;
  logic            rd_valid_reg;
  logic [31:0]     rd_data_reg;
  logic [15:0]     ovf_reg;
  logic [15:0]     ovf_next;
  logic [31:0]     mem [DEPTH];

  logic [4:0] evt;
  logic       wr_req;
  logic       pop;
  logic       push;
  logic       drop;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_edge
      assign evt[gi] = TRG_PLS[gi] & ~trg_d_reg[gi];
    end
  endgenerate

  // Flags are registered, so a pop at full frees the slot the same-cycle push needs.
  assign wr_req = LOG_EN && (|evt);
  assign pop    = RD_REQ && !empty_reg && !LOG_CLR;
  assign push   = wr_req && (!full_reg || pop) && !LOG_CLR;
  assign drop   = wr_req && !push && !LOG_CLR;

  always_comb begin
    level_next = level_reg;
    if (push && !pop)
      level_next = level_reg + 1'b1;
    else if (pop && !push)
      level_next = level_reg - 1'b1;
  end

  always_comb begin
    ovf_next = ovf_reg;
    if (drop && (ovf_reg != 16'hFFFF))
      ovf_next = ovf_reg + 1'b1;
  end

  // Storage has no reset; stale contents are never visible because EMPTY gates reads.
  always_ff @(posedge CLK160M) begin
    if (push)
      mem[wr_ptr_reg] <= {evt, ts_reg};
  end

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      ts_reg       <= '0;
      trg_d_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      ovf_reg      <= '0;
    end else begin
      trg_d_reg <= TRG_PLS;
      if (LOG_CLR) begin
        ts_reg       <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        level_reg    <= '0;
        empty_reg    <= 1'b1;
        full_reg     <= 1'b0;
        rd_valid_reg <= 1'b0;
        ovf_reg      <= '0;
      end else begin
        ts_reg       <= ts_reg + 1'b1;
        level_reg    <= level_next;
        empty_reg    <= (level_next == '0);
        full_reg     <= (level_next == LW'(DEPTH));
        rd_valid_reg <= pop;
        ovf_reg      <= ovf_next;
        if (push)
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop) begin
          rd_ptr_reg  <= rd_ptr_reg + 1'b1;
          rd_data_reg <= mem[rd_ptr_reg];
        end
      end
    end
  end

  assign RD_DATA  = rd_data_reg;
  assign RD_VALID = rd_valid_reg;
  assign LEVEL    = level_reg;
  assign EMPTY    = empty_reg;
  assign FULL     = full_reg;
  assign OVF_CNT  = ovf_reg;

endmodule

// File: tb/tb_ptmch_evlog.sv
// Bench for ptmch_evlog: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ptmch_evlog;

  localparam int DEPTH = 64;
  localparam int LW    = 7;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [4:0]    trg     = '0;
  logic          log_en  = 1'b1;
  logic          log_clr = 1'b0;
  logic          rd_req  = 1'b0;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic [15:0]   ovf_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 0;

  always #5 clk = ~clk;

  ptmch_evlog #(.DEPTH(DEPTH), .TS_W(27)) dut (
    .CLK160M (clk),
    .RESET_N (rst_n),
    .TRG_PLS (trg),
    .LOG_EN  (log_en),
    .LOG_CLR (log_clr),
    .RD_REQ  (rd_req),
    .RD_DATA (rd_data),
    .RD_VALID(rd_valid),
    .LEVEL   (level),
    .EMPTY   (empty),
    .FULL    (full),
    .OVF_CNT (ovf_cnt)
  );

  // Reference model: a plain queue of entries plus counters.
  logic [31:0] m_q[$];
  logic [26:0] m_ts    = '0;
  logic [4:0]  m_trg_d = '0;
  logic [31:0] m_data  = '0;
  logic        m_valid = 1'b0;
  int          m_ovf   = 0;

  initial begin : model
    logic [4:0] e;
    int         sz;
    bit         do_pop;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_ts = '0; m_trg_d = '0; m_data = '0; m_valid = 1'b0; m_ovf = 0;
      end else begin
        e = trg & ~m_trg_d;
        m_trg_d = trg;
        if (log_clr) begin
          m_q.delete();
          m_ts = '0; m_ovf = 0; m_valid = 1'b0;
        end else begin
          sz = m_q.size();
          do_pop = rd_req && (sz != 0);
          m_valid = do_pop;
          if (do_pop) m_data = m_q.pop_front();
          if (log_en && (e != 0)) begin
            if (sz < DEPTH || do_pop) m_q.push_back({e, m_ts});
            else if (m_ovf < 65535) m_ovf++;
          end
          m_ts = m_ts + 27'd1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data",  rd_data, m_data);
        chk("level",    32'(level), 32'(m_q.size()));
        chk("empty",    32'(empty), 32'(m_q.size() == 0));
        chk("full",     32'(full),  32'(m_q.size() == DEPTH));
        chk("ovf_cnt",  32'(ovf_cnt), 32'(m_ovf));
        if (rd_valid) $display("pop data=%h level=%0d ovf=%0d t=%0t", rd_data, level, ovf_cnt, $time);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_lit(input string name, input logic [31:0] exp);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    chk({name, "_valid"}, 32'(rd_valid), 32'd1);
    chk(name, rd_data, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int b;
    step(2);
    check_en = 1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data",  rd_data, 32'd0);

    // Pulse held 3 cycles starting at ts=10 gives one entry.
    rst_n = 1'b1;
    step(10);
    trg = 5'b00001;
    step(3);
    trg = 5'b00000;
    step(2);
    pop_lit("t1_pop", 32'h0800000A);
    chk("t1_level", 32'(level), 32'd0);

    // Two bits rising together at ts=100 merge into one entry.
    b = 0;
    while (m_ts != 27'd100 && b < 1000) begin step(1); b++; end
    chk("t2_reach_ts", 32'(m_ts), 32'd100);
    trg = 5'b10010;
    step(1);
    trg = 5'b00000;
    step(1);
    pop_lit("t2_pop", 32'h90000064);
    chk("t2_ovf", 32'(ovf_cnt), 32'd0);

    // 70 edges with no reads: 64 stored, 6 dropped.
    for (int i = 0; i < 70; i++) begin
      trg = 5'b00001; step(1);
      trg = 5'b00000; step(1);
    end
    chk("t3_full",  32'(full),    32'd1);
    chk("t3_level", 32'(level),   32'd64);
    chk("t3_ovf",   32'(ovf_cnt), 32'd6);

    // Pop and push together at full.
    trg = 5'b00001; rd_req = 1'b1;
    step(1);
    trg = 5'b00000; rd_req = 1'b0;
    chk("t4_level", 32'(level),    32'd64);
    chk("t4_ovf",   32'(ovf_cnt),  32'd6);
    chk("t4_valid", 32'(rd_valid), 32'd1);
    rd_req = 1'b1;
    step(66);
    rd_req = 1'b0;
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_level0", 32'(level), 32'd0);
    step(1);

    // Request while empty coincident with an edge.
    trg = 5'b00010; rd_req = 1'b1;
    step(1);
    chk("t5_novalid", 32'(rd_valid), 32'd0);
    chk("t5_level",   32'(level),    32'd1);
    step(1);
    chk("t5_valid", 32'(rd_valid), 32'd1);
    rd_req = 1'b0; trg = 5'b00000;
    step(1);

    // Edges ignored while logging disabled.
    log_en = 1'b0; trg = 5'b00100;
    step(1);
    trg = 5'b00000;
    step(1);
    log_en = 1'b1;
    chk("t_dis_level", 32'(level), 32'd0);

    // Timestamp wrap.
    force dut.ts_reg = 27'h7FFFFFE;
    m_ts = 27'h7FFFFFE;
    #1 release dut.ts_reg;
    step(1);
    trg = 5'b00001; step(1);
    trg = 5'b00011; step(1);
    trg = 5'b00000; step(1);
    pop_lit("t6_wrap_hi", 32'h0FFFFFFF);
    pop_lit("t6_wrap_lo", 32'h10000000);

    // Clear with a coincident edge, then ts restarts at 0.
    trg = 5'b10000; step(1);
    chk("t7_pre_level", 32'(level),   32'd1);
    chk("t7_pre_ovf",   32'(ovf_cnt), 32'd6);
    trg = 5'b10100; log_clr = 1'b1;
    step(1);
    log_clr = 1'b0;
    chk("t7_level", 32'(level),    32'd0);
    chk("t7_ovf",   32'(ovf_cnt),  32'd0);
    chk("t7_empty", 32'(empty),    32'd1);
    chk("t7_valid", 32'(rd_valid), 32'd0);
    trg = 5'b01000; step(1);
    trg = 5'b00000; step(1);
    pop_lit("t7_ts0", 32'h40000000);

    // Asynchronous reset in the middle of operation.
    trg = 5'b00001; step(1);
    trg = 5'b00000; step(1);
    chk("t8_pre_level", 32'(level), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_async_empty", 32'(empty), 32'd1);
    step(1);
    chk("t8_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    step(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
